// File: rtl/pulse_measure_pkg.sv
//------------------------------------------------------------------------------
// Module : pulse_measure_pkg
// Brief  : Shared constants, FSM encoding and helpers for the pulse measurement block
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef MASTER_CLK_CYC_PER_MS
`define MASTER_CLK_CYC_PER_MS 50000
`endif

package pulse_measure_pkg;

  localparam int unsigned c_len_w = 8;
  localparam logic [c_len_w-1:0] c_len_sat = 8'hFF;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2
  } meas_state_t;

  function automatic logic [c_len_w-1:0] sat_inc(input logic [c_len_w-1:0] value);
    return (value == c_len_sat) ? value : value + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_in_filter.sv
//------------------------------------------------------------------------------
// Module : pulse_in_filter
// Brief  : 2-flop synchronizer plus optional glitch filter (PULSE_MEASURE_FILTER_EN)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_in_filter #(
  parameter int FILTER_CYC = 16
) (
  input  logic masterClk,
  input  logic masterRst,
  input  logic pulseIn,
  output logic sIn
);

  logic r_sync1;
  logic r_sync2;

  // Synchronizer keeps sampling through reset so a level already high at release is seen at once
  always_ff @(posedge masterClk) begin
    r_sync1 <= pulseIn;
    r_sync2 <= r_sync1;
  end

`ifdef PULSE_MEASURE_FILTER_EN
  localparam int c_cnt_w = $clog2(FILTER_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_CYC - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_filt;

  // r_cnt tracks consecutive cycles the synchronized input disagrees with the filtered level
  always_ff @(posedge masterClk) begin
    if (masterRst) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sIn = r_filt;
`else
  logic w_unused;
  assign w_unused = masterRst | (FILTER_CYC == 0);
  assign sIn      = r_sync2;
`endif

endmodule

`default_nettype wire

// File: rtl/pulse_measure.sv
//------------------------------------------------------------------------------
// Module : pulse_measure
// Brief  : Measures pulse high time in whole ms (0-255) with valid/ack result handshake;
//          optional input glitch filter via PULSE_MEASURE_FILTER_EN
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_measure
  import pulse_measure_pkg::*;
#(
  parameter int CYC_PER_MS = `MASTER_CLK_CYC_PER_MS,
  parameter int FILTER_CYC = 16
) (
  input  logic               masterClk,
  input  logic               masterRst,
  input  logic               pulseIn,
  input  logic               lengthAck,
  output logic [c_len_w-1:0] pulseLength,
  output logic               lengthValid,
  output logic               overflow,
  output logic               overrun
);

  localparam int c_cyc_w = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(CYC_PER_MS - 1);

`ifdef PULSE_MEASURE_FILTER_EN
  localparam int c_settle = FILTER_CYC;
`else
  localparam int c_settle = 0;
`endif
  localparam int c_settle_w = $clog2(c_settle + 2);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(c_settle);

  logic w_s_in;
  logic r_s_d;
  logic w_rise;
  logic w_fall;

  pulse_in_filter #(
    .FILTER_CYC(FILTER_CYC)
  ) u_in_filter (
    .masterClk(masterClk),
    .masterRst(masterRst),
    .pulseIn  (pulseIn),
    .sIn      (w_s_in)
  );

  always_ff @(posedge masterClk) begin
    if (masterRst) r_s_d <= 1'b0;
    else           r_s_d <= w_s_in;
  end

  assign w_rise = w_s_in & ~r_s_d;
  assign w_fall = ~w_s_in & r_s_d;

  meas_state_t          r_state;
  logic [c_settle_w-1:0] r_settle;
  logic [c_cyc_w-1:0]   r_cyc_cnt;
  logic [c_len_w-1:0]   r_ms_cnt;
  logic                 r_sat;
  logic [c_len_w-1:0]   r_len;
  logic                 r_valid;
  logic                 r_ovf;
  logic                 r_overrun;

  logic                 w_count;
  logic                 w_wrap;
  logic [c_len_w-1:0]   w_ms_next;
  logic                 w_sat_next;
  logic                 w_new_result;

  // The rising-edge cycle itself is not counted, so a pulse of N sIn-high cycles
  // accumulates N-1 counted cycles before its falling edge.
  always_comb begin
    w_count      = (r_state == ST_MEASURE) && w_s_in;
    w_wrap       = w_count && (r_cyc_cnt == c_cyc_last);
    w_ms_next    = w_wrap ? sat_inc(r_ms_cnt) : r_ms_cnt;
    w_sat_next   = r_sat | (w_wrap && (r_ms_cnt == c_len_sat));
    w_new_result = (r_state == ST_MEASURE) && w_fall;
  end

  always_ff @(posedge masterClk) begin
    if (masterRst) begin
      r_state   <= ST_ARM;
      r_settle  <= '0;
      r_cyc_cnt <= '0;
      r_ms_cnt  <= '0;
      r_sat     <= 1'b0;
      r_len     <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM: begin
          // Filtered input needs time to reflect the real pin level before arming
          if (r_settle != c_settle_last) r_settle <= r_settle + 1'b1;
          else if (!w_s_in)              r_state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_rise) begin
            r_cyc_cnt <= '0;
            r_ms_cnt  <= '0;
            r_sat     <= 1'b0;
            r_state   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_count) r_cyc_cnt <= w_wrap ? '0 : r_cyc_cnt + 1'b1;
          r_ms_cnt <= w_ms_next;
          r_sat    <= w_sat_next;
          if (w_fall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_ARM;
      endcase

      if (w_new_result) begin
        r_len   <= w_ms_next;
        r_ovf   <= w_sat_next;
        r_valid <= 1'b1;
        if (r_valid && !lengthAck) r_overrun <= 1'b1;
      end else if (lengthAck && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign pulseLength = r_len;
  assign lengthValid = r_valid;
  assign overflow    = r_ovf;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_pulse_measure.sv
//------------------------------------------------------------------------------
// Module : tb_pulse_measure
// Brief  : Randomized self-checking bench for pulse_measure against a pulse-level model
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_measure;

  localparam int C_MS  = 10;
  localparam int F_CYC = 4;
`ifdef PULSE_MEASURE_FILTER_EN
  localparam int F_EFF = F_CYC;
`else
  localparam int F_EFF = 0;
`endif

  logic       masterClk = 1'b0;
  logic       masterRst;
  logic       pulseIn;
  logic       lengthAck;
  logic [7:0] pulseLength;
  logic       lengthValid;
  logic       overflow;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  always #5 masterClk = ~masterClk;

  pulse_measure #(
    .CYC_PER_MS(C_MS),
    .FILTER_CYC(F_CYC)
  ) dut (
    .masterClk  (masterClk),
    .masterRst  (masterRst),
    .pulseIn    (pulseIn),
    .lengthAck  (lengthAck),
    .pulseLength(pulseLength),
    .lengthValid(lengthValid),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  // Pulse-level model: the input history, the conditioned level, and the result register.
  int  cyc      = 0;
  int  last_rst = -1000;
  bit  p_ring[0:63];
  bit  m_filt, m_s_prev, m_armed, m_in_pulse;
  int  m_run;
  int  m_len;
  bit  m_valid, m_ovf, m_ovr;
  int  e_len;
  bit  e_valid, e_ovf, e_ovr;

  function automatic bit p_at(input int c);
    if (c < 0) return 1'b0;
    return p_ring[c % 64];
  endfunction

  task automatic step(input bit p, input bit ack, input bit rst);
    bit s, v, all_eq, result;
    int n, q;
    pulseIn   = p;
    lengthAck = ack;
    masterRst = rst;
    p_ring[cyc % 64] = p;
    result = 1'b0;
    n = 0;

    // conditioned level: 2-cycle delayed pin, optionally held until F samples agree
    if (F_EFF == 0) begin
      m_filt = p_at(cyc - 2);
    end else if (cyc == last_rst + 1) begin
      m_filt = 1'b0;
    end else if (cyc - F_EFF > last_rst) begin
      v = p_at(cyc - 3);
      all_eq = 1'b1;
      for (int k = 3; k <= F_EFF + 2; k++) if (p_at(cyc - k) != v) all_eq = 1'b0;
      if (all_eq) m_filt = v;
    end
    s = m_filt;

    if (rst) begin
      last_rst   = cyc;
      m_armed    = 1'b0;
      m_in_pulse = 1'b0;
      m_len = 0; m_valid = 0; m_ovf = 0; m_ovr = 0;
    end else begin
      if (!m_armed) begin
        if ((cyc - last_rst > F_EFF) && !s) m_armed = 1'b1;
      end else if (m_in_pulse) begin
        if (s) m_run++;
        else begin
          result = 1'b1;
          n = m_run;
          m_in_pulse = 1'b0;
        end
      end else if (s && !m_s_prev) begin
        m_in_pulse = 1'b1;
        m_run = 1;
      end

      if (result) begin
        q = (n - 1) / C_MS;
        if (m_valid && !ack) m_ovr = 1'b1;
        m_len   = (q > 255) ? 255 : q;
        m_ovf   = (q > 255);
        m_valid = 1'b1;
      end else if (ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    m_s_prev = s;
    cyc++;

    @(posedge masterClk);
    #1;
    e_len = m_len; e_valid = m_valid; e_ovf = m_ovf; e_ovr = m_ovr;
    chk_en = 1'b1;
  endtask

  always @(negedge masterClk) begin
    if (chk_en) begin
      n_checks++;
      if (pulseLength !== 8'(e_len) || lengthValid !== e_valid ||
          overflow !== e_ovf || overrun !== e_ovr) begin
        n_errors++;
        $display("FAIL cycle_compare cyc=%0d: got len=%0d valid=%0b ovf=%0b ovr=%0b, want len=%0d valid=%0b ovf=%0b ovr=%0b",
                 cyc, pulseLength, lengthValid, overflow, overrun, e_len, e_valid, e_ovf, e_ovr);
      end
    end
  end

  task automatic chk_lit(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0, 1'b0);
    repeat (lo) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int hi, lo;

    // pin already high across reset release
    repeat (4) step(1'b1, 1'b0, 1'b1);
    chk_lit("reset_len", int'(pulseLength), 0);
    chk_lit("reset_valid", int'(lengthValid), 0);
    chk_lit("reset_overrun", int'(overrun), 0);
    repeat (50) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk_lit("no_result_for_preexisting_pulse", int'(lengthValid), 0);

    pulse(35, 10);
    chk_lit("p35_len", int'(pulseLength), 3);
    chk_lit("p35_ovf", int'(overflow), 0);
    chk_lit("p35_valid", int'(lengthValid), 1);
    step(1'b0, 1'b1, 1'b0);
    chk_lit("ack_clears_valid", int'(lengthValid), 0);

    pulse(9, 10);
    chk_lit("p9_len", int'(pulseLength), 0);
    chk_lit("p9_valid", int'(lengthValid), 1);
    step(1'b0, 1'b1, 1'b0);

    pulse(2560, 10);
    chk_lit("p2560_len", int'(pulseLength), 255);
    chk_lit("p2560_ovf", int'(overflow), 0);
    step(1'b0, 1'b1, 1'b0);

    pulse(3000, 10);
    chk_lit("p3000_len", int'(pulseLength), 255);
    chk_lit("p3000_ovf", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0);

    pulse(25, 10);
    pulse(25, 10);
    chk_lit("overrun_len", int'(pulseLength), 2);
    chk_lit("overrun_set", int'(overrun), 1);
    step(1'b0, 1'b1, 1'b0);
    chk_lit("overrun_ack_valid", int'(lengthValid), 0);
    chk_lit("overrun_ack_clear", int'(overrun), 0);

    // ack lands exactly in the cycle the second result is written
    pulse(15, 10);
    chk_lit("first_len", int'(pulseLength), 1);
    repeat (25) step(1'b1, 1'b0, 1'b0);
    repeat (F_EFF + 2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_lit("ack_same_cycle_valid", int'(lengthValid), 1);
    chk_lit("ack_same_cycle_len", int'(pulseLength), 2);
    chk_lit("ack_same_cycle_overrun", int'(overrun), 0);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // reset halfway through a 40-cycle pulse, with a result still pending
    repeat (20) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_lit("midreset_valid", int'(lengthValid), 0);
    chk_lit("midreset_len", int'(pulseLength), 0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    chk_lit("midreset_remainder_dropped", int'(lengthValid), 0);

`ifdef PULSE_MEASURE_FILTER_EN
    pulse(3, 15);
    chk_lit("glitch_ignored", int'(lengthValid), 0);
    repeat (15) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (15) step(1'b1, 1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0);
    chk_lit("gap_single_len", int'(pulseLength), 3);
    chk_lit("gap_single_valid", int'(lengthValid), 1);
    chk_lit("gap_single_overrun", int'(overrun), 0);
    step(1'b0, 1'b1, 1'b0);
`endif

    // randomized pulses, gaps and acknowledges
    for (int i = 0; i < 150; i++) begin
      hi = (i % 25 == 0) ? int'($urandom_range(2545, 2575)) : int'($urandom_range(1, 45));
      lo = int'($urandom_range(1, 25));
      for (int k = 0; k < hi; k++)
        step(1'b1, ($urandom_range(0, 3) == 0), (i % 40 == 17) && (k == hi / 2));
      for (int k = 0; k < lo; k++)
        step(1'b0, ($urandom_range(0, 3) == 0), 1'b0);
    end
    repeat (10) step(1'b0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
- Receive-side counterpart of the satellite pulse generator.
- Samples an external pulse input, measures its high time in whole milliseconds (0-255) and presents the result to the register/link layer through a valid/ack handshake.
- Used for sensor inputs and for loop-back checking of generated pulses.
- Sits between the input pin synchronizer domain and the satellite register file; all logic is on masterClk.

Parameters:
- CYC_PER_MS, default `MASTER_CLK_CYC_PER_MS: masterClk cycles per millisecond; must be >= 2.
- FILTER_CYC, default 16: glitch-filter stability length in cycles; only used when the optional feature is enabled; must be >= 1.

Ports:
- masterClk  in  1  master clock; all state updates on posedge.
- masterRst  in  1  synchronous, active-high reset.
- pulseIn  in  1  asynchronous external pulse input, active high.
- lengthAck  in  1  consumer acknowledge of the current result; one-cycle strobe or level.
- pulseLength  out  8  measured high time in whole ms, saturated at 255.
- lengthValid  out  1  pulseLength holds an unacknowledged result.
- overflow  out  1  the measured pulse exceeded 255 ms; qualified by lengthValid.
- overrun  out  1  sticky; a result was overwritten before it was acked.

Behaviour:
- Reset: while masterRst=1, all outputs are driven to 0, the FSM goes to ARM and all counters are cleared. Reset mid-pulse discards the measurement.
- Input conditioning: 2-flop synchronizer on pulseIn gives sIn. Edge detection uses sIn against a registered copy.
- Latency: 2 cycles from pulseIn to sIn, plus filter latency when that feature is enabled.
- FSM state ARM: wait for sIn=0, then go to IDLE. This prevents measuring a pulse already high at reset release.
- FSM state IDLE: on a rising edge of sIn, clear msCnt (8 bit) and cycCnt (clog2(CYC_PER_MS) bits), then go to MEASURE.
- FSM state MEASURE: cycCnt counts 0..CYC_PER_MS-1 and wraps.
  - On wrap, msCnt increments.
  - If msCnt is already 255, msCnt holds and an internal sat flag is set.
- Falling edge of sIn in MEASURE, next cycle:
  - pulseLength <= msCnt, i.e. completed ms only, truncated; a pulse shorter than 1 ms reports 0.
  - overflow <= sat.
  - lengthValid <= 1.
  - FSM returns to IDLE.
- A wrap and a falling edge in the same cycle: the wrap counts, so msCnt+1 is reported (saturating).
- Handshake:
  - lengthValid stays 1 until a cycle with lengthAck=1; lengthValid clears on the next edge.
  - pulseLength and overflow are stable while lengthValid=1, unless overwritten.
  - lengthAck while lengthValid=0 is ignored.
- New result while lengthValid=1 and no ack in the same cycle: the new result overwrites, lengthValid stays 1, overrun <= 1.
- New result and lengthAck in the same cycle: the new result is loaded, lengthValid stays 1, overrun is unchanged.
- overrun clears only on a lengthAck cycle that does not coincide with a new overwrite.
- A rising edge that arrives in the same cycle as the result write starts a new measurement; back-to-back pulses are not lost.

Optional Feature:
- Macro: PULSE_MEASURE_FILTER_EN.
- Defined: a glitch filter sits between the synchronizer and edge detection.
  - The filtered level changes only after sIn has held the new value for FILTER_CYC consecutive cycles.
  - Total input latency is 2+FILTER_CYC cycles.
  - Pulses or gaps shorter than FILTER_CYC cycles are ignored entirely.
  - The filter output resets to 0.
- Undefined: the filter is absent, edge detection uses sIn directly, and FILTER_CYC is unused.

Decomposition:
- Shared env/package (alongside `MASTER_CLK_CYC_PER_MS):
  - FSM state encodings ARM/IDLE/MEASURE (2 bit).
  - Pulse length width constant 8.
  - Saturation value 8'hFF.
- Natural sub-module: pulse_in_filter.
  - Contains the synchronizer and optional glitch filter.
  - Ports: masterClk, masterRst, pulseIn -> sIn.
  - Reusable by other satellite input blocks.

Test Plan (CYC_PER_MS=10, FILTER_CYC=4 in simulation):
- Reset release with pulseIn already high for 50 cycles, then low -> no lengthValid; the next 35-cycle pulse reports pulseLength=3, overflow=0.
- 9-cycle pulse -> pulseLength=0 and lengthValid=1. Then a 2560-cycle pulse -> pulseLength=255, overflow=0. Then a 3000-cycle pulse -> pulseLength=255, overflow=1.
- Two 25-cycle pulses with no ack -> second result pulseLength=2, overrun=1. Then an ack -> lengthValid=0 and overrun=0 one cycle later.
- Ack asserted in the exact cycle a new result is written -> lengthValid stays 1, new value present, overrun=0.
- masterRst asserted halfway through a 40-cycle pulse -> all outputs 0; the remainder of that pulse is not reported.
- With PULSE_MEASURE_FILTER_EN defined: a 3-cycle glitch -> no result. A 1-cycle low gap inside a 30-cycle pulse -> a single result, pulseLength=3.
